// File: rtl/line_edit_pkg.sv
// Shared types and ASCII constants for the command-line editor.
// to_upper is used only when LINE_EDIT_UPPERCASE_EN is defined.
package line_edit_pkg;

  typedef enum logic [1:0] {
    EDIT,
    HOLD,
    CLEAR
  } state_t;

  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z)
      return c - 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/line_edit_controller.sv
// Keystroke-to-command-line editor with echo and valid/ready line hand-off.
// Define LINE_EDIT_UPPERCASE_EN to fold lower-case letters to upper-case.
module line_edit_controller
  import line_edit_pkg::*;
#(
  parameter int MAX_CHARS = 32,
  parameter int CHAR_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        key_pressed_in,
  input  logic [CHAR_W-1:0]           character_in,
  input  logic                        enter_pressed_in,
  input  logic                        bksp_pressed_in,
  input  logic                        line_ready_in,
  output logic                        line_valid_out,
  output logic [MAX_CHARS*CHAR_W-1:0] line_out,
  output logic [$clog2(MAX_CHARS+1)-1:0] line_len_out,
  output logic                        echo_valid_out,
  output logic [CHAR_W-1:0]           echo_char_out,
  output logic                        echo_erase_out,
  output logic                        busy_out,
  output logic [CNT_W-1:0]            dropped_count_out
);

  localparam int LEN_W = $clog2(MAX_CHARS + 1);
  localparam int IDX_W = $clog2(MAX_CHARS);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CHARS - 1);
  localparam logic [CHAR_W-1:0] SPACE   = CHAR_W'(CHAR_SPACE);

  state_t state_q, state_d;

  logic [CHAR_W-1:0] line_buf [MAX_CHARS];
  logic [LEN_W-1:0]  len_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [CNT_W-1:0]  dropped_q;
  logic              echo_valid_q;
  logic              echo_erase_q;
  logic [CHAR_W-1:0] echo_char_q;

  logic              in_edit;
  logic              do_key;
  logic              do_bksp;
  logic              drop;
  logic [CHAR_W-1:0] stored_char;

`ifdef LINE_EDIT_UPPERCASE_EN
  assign stored_char = CHAR_W'(to_upper(8'(character_in)));
`else
  assign stored_char = character_in;
`endif

  // Enter outranks backspace outranks key; losers vanish without counting.
  assign in_edit = (state_q == EDIT);
  assign do_key  = in_edit && key_pressed_in && !enter_pressed_in
                   && !bksp_pressed_in && (len_q < MAX_LEN);
  assign do_bksp = in_edit && bksp_pressed_in && !enter_pressed_in
                   && (len_q != '0);
  assign drop    = (in_edit && key_pressed_in && !enter_pressed_in
                    && !bksp_pressed_in && (len_q == MAX_LEN))
                 || (!in_edit && (key_pressed_in || bksp_pressed_in));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= EDIT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EDIT:  if (enter_pressed_in && len_q != '0) state_d = HOLD;
      HOLD:  if (line_ready_in) state_d = CLEAR;
      CLEAR: if (clr_idx_q == LAST_IDX) state_d = EDIT;
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < MAX_CHARS; i++) line_buf[i] <= SPACE;
      len_q        <= '0;
      clr_idx_q    <= '0;
      dropped_q    <= '0;
      echo_valid_q <= 1'b0;
      echo_erase_q <= 1'b0;
      echo_char_q  <= '0;
    end else begin
      echo_valid_q <= do_key || do_bksp;
      echo_erase_q <= do_bksp;
      echo_char_q  <= do_key ? stored_char : (do_bksp ? SPACE : '0);
      if (do_key) begin
        line_buf[IDX_W'(len_q)] <= stored_char;
        len_q <= len_q + 1'b1;
      end
      if (do_bksp) begin
        line_buf[IDX_W'(len_q - 1'b1)] <= SPACE;
        len_q <= len_q - 1'b1;
      end
      // Length drops to zero as the clear pass starts.
      if (state_q == HOLD && line_ready_in) begin
        len_q     <= '0;
        clr_idx_q <= '0;
      end
      if (state_q == CLEAR) begin
        line_buf[clr_idx_q] <= SPACE;
        clr_idx_q <= clr_idx_q + 1'b1;
      end
      if (drop && dropped_q != '1) dropped_q <= dropped_q + 1'b1;
    end
  end

  for (genvar g = 0; g < MAX_CHARS; g++) begin : g_line
    assign line_out[g*CHAR_W +: CHAR_W] = line_buf[g];
  end

  assign line_valid_out    = (state_q == HOLD);
  assign busy_out          = (state_q != EDIT);
  assign line_len_out      = len_q;
  assign echo_valid_out    = echo_valid_q;
  assign echo_erase_out    = echo_erase_q;
  assign echo_char_out     = echo_char_q;
  assign dropped_count_out = dropped_q;

endmodule

// File: tb/tb_line_edit_controller.sv
// Directed self-checking bench for line_edit_controller.
module tb_line_edit_controller;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         key_pressed_in;
  logic [7:0]   character_in;
  logic         enter_pressed_in;
  logic         bksp_pressed_in;
  logic         line_ready_in;
  logic         line_valid_out;
  logic [255:0] line_out;
  logic [5:0]   line_len_out;
  logic         echo_valid_out;
  logic [7:0]   echo_char_out;
  logic         echo_erase_out;
  logic         busy_out;
  logic [7:0]   dropped_count_out;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_line;
  logic [255:0] blank;
  logic [255:0] held;

  line_edit_controller dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .key_pressed_in    (key_pressed_in),
    .character_in      (character_in),
    .enter_pressed_in  (enter_pressed_in),
    .bksp_pressed_in   (bksp_pressed_in),
    .line_ready_in     (line_ready_in),
    .line_valid_out    (line_valid_out),
    .line_out          (line_out),
    .line_len_out      (line_len_out),
    .echo_valid_out    (echo_valid_out),
    .echo_char_out     (echo_char_out),
    .echo_erase_out    (echo_erase_out),
    .busy_out          (busy_out),
    .dropped_count_out (dropped_count_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] exp_ch(input logic [7:0] c);
`ifdef LINE_EDIT_UPPERCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
    return c;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic press_key(input logic [7:0] c);
    key_pressed_in = 1'b1;
    character_in   = c;
    tick();
    key_pressed_in = 1'b0;
  endtask

  task automatic press_bksp();
    bksp_pressed_in = 1'b1;
    tick();
    bksp_pressed_in = 1'b0;
  endtask

  task automatic press_enter();
    enter_pressed_in = 1'b1;
    tick();
    enter_pressed_in = 1'b0;
  endtask

  task automatic accept_and_clear();
    line_ready_in = 1'b1;
    tick();
    line_ready_in = 1'b0;
    check("clr_len0", line_len_out, 0);
    check("clr_valid0", line_valid_out, 0);
    repeat (31) tick();
    check("clr_busy_last", busy_out, 1);
    tick();
    check("clr_done_idle", busy_out, 0);
    check("clr_blank", line_out, blank);
  endtask

  initial begin
    blank = {32{8'h20}};
    rst_in = 1'b0;
    key_pressed_in = 1'b0;
    character_in = 8'h00;
    enter_pressed_in = 1'b0;
    bksp_pressed_in = 1'b0;
    line_ready_in = 1'b0;
    repeat (2) tick();
    check("rst_valid", line_valid_out, 0);
    check("rst_len", line_len_out, 0);
    check("rst_echo", echo_valid_out, 0);
    check("rst_echo_char", echo_char_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_dropped", dropped_count_out, 0);
    check("rst_line", line_out, blank);
    rst_in = 1'b1;
    tick();

    // "add" then hold for five cycles without ready
    press_key(8'h61);
    check("a_echo_v", echo_valid_out, 1);
    check("a_echo_c", echo_char_out, exp_ch(8'h61));
    check("a_echo_e", echo_erase_out, 0);
    check("a_len", line_len_out, 1);
    tick();
    check("echo_pulse_one", echo_valid_out, 0);
    press_key(8'h64);
    press_key(8'h64);
    exp_line = blank;
    exp_line[7:0]   = exp_ch(8'h61);
    exp_line[15:8]  = 8'h64;
    exp_line[23:16] = 8'h64;
    check("add_line", line_out, exp_line);
    press_enter();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", line_valid_out, 1);
      check("hold_len", line_len_out, 3);
      check("hold_line", line_out, exp_line);
      check("hold_busy", busy_out, 1);
      tick();
    end
    accept_and_clear();

    // backspace behaviour
    press_key(8'h78);
    press_bksp();
    check("bk_echo_v", echo_valid_out, 1);
    check("bk_echo_e", echo_erase_out, 1);
    check("bk_echo_c", echo_char_out, 8'h20);
    check("bk_len", line_len_out, 0);
    check("bk_line", line_out, blank);
    press_bksp();
    check("bk0_echo", echo_valid_out, 0);
    check("bk0_len", line_len_out, 0);
    check("bk0_drop", dropped_count_out, 0);

    // empty enter ignored
    press_enter();
    check("e0_valid", line_valid_out, 0);
    check("e0_busy", busy_out, 0);

    // overflow: 33 keys
    exp_line = blank;
    for (int i = 0; i < 32; i++) begin
      press_key(8'h30 + 8'(i));
      exp_line[i*8 +: 8] = 8'h30 + 8'(i);
    end
    check("full_len", line_len_out, 32);
    press_key(8'h21);
    check("ovf_echo", echo_valid_out, 0);
    check("ovf_drop", dropped_count_out, 1);
    check("ovf_len", line_len_out, 32);
    check("ovf_line", line_out, exp_line);
    press_enter();
    check("full_valid", line_valid_out, 1);
    accept_and_clear();

    // enter + key together, then keys during HOLD
    press_key(8'h41);
    press_key(8'h42);
    enter_pressed_in = 1'b1;
    key_pressed_in = 1'b1;
    character_in = 8'h43;
    tick();
    enter_pressed_in = 1'b0;
    key_pressed_in = 1'b0;
    check("ek_valid", line_valid_out, 1);
    check("ek_len", line_len_out, 2);
    check("ek_drop", dropped_count_out, 1);
    check("ek_echo", echo_valid_out, 0);
    held = line_out;
    check("ek_line", held[23:0], 24'h204241);
    press_key(8'h44);
    check("hk_drop", dropped_count_out, 2);
    check("hk_len", line_len_out, 2);
    press_bksp();
    check("hb_drop", dropped_count_out, 3);
    press_enter();
    check("he_valid", line_valid_out, 1);
    check("he_drop", dropped_count_out, 3);
    check("he_line", line_out, held);

    // reset in the middle of the clear pass
    line_ready_in = 1'b1;
    tick();
    line_ready_in = 1'b0;
    repeat (10) tick();
    check("mc_busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    check("mr_busy", busy_out, 0);
    check("mr_valid", line_valid_out, 0);
    check("mr_len", line_len_out, 0);
    check("mr_drop", dropped_count_out, 0);
    check("mr_line", line_out, blank);
    tick();
    rst_in = 1'b1;
    tick();

    // case folding (identity unless LINE_EDIT_UPPERCASE_EN)
    press_key(8'h71);
    check("q_echo", echo_char_out, exp_ch(8'h71));
    press_key(8'h31);
    check("one_echo", echo_char_out, 8'h31);
    held = line_out;
    check("q_store", held[15:0], {8'h31, exp_ch(8'h71)});
    check("q_len", line_len_out, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
